// File: rtl/bp_me_mem_router.sv
// One-beat request/response router between num_source_p sources and num_sink_p sinks.
// Per-sink tag FIFOs remember request order so in-order responses return to their originator.
module bp_me_mem_router #(
   parameter int num_source_p   = 2,
   parameter int num_sink_p     = 4,
   parameter int header_width_p = 64,
   parameter int data_width_p   = 64,
   parameter int tag_els_p      = 4,
   localparam int lg_src = (num_source_p > 1) ? $clog2(num_source_p) : 1,
   localparam int lg_snk = (num_sink_p > 1) ? $clog2(num_sink_p) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [num_source_p*header_width_p-1:0] src_fwd_header_i,
   input  logic [num_source_p*data_width_p-1:0]   src_fwd_data_i,
   input  logic [num_source_p-1:0]                src_fwd_v_i,
   input  logic [num_source_p*lg_snk-1:0]         src_fwd_dst_i,
   output logic [num_source_p-1:0]                src_fwd_ready_and_o,
   output logic [num_sink_p*header_width_p-1:0]   snk_fwd_header_o,
   output logic [num_sink_p*data_width_p-1:0]     snk_fwd_data_o,
   output logic [num_sink_p-1:0]                  snk_fwd_v_o,
   input  logic [num_sink_p-1:0]                  snk_fwd_ready_and_i,
   input  logic [num_sink_p*header_width_p-1:0]   snk_rev_header_i,
   input  logic [num_sink_p*data_width_p-1:0]     snk_rev_data_i,
   input  logic [num_sink_p-1:0]                  snk_rev_v_i,
   output logic [num_sink_p-1:0]                  snk_rev_ready_and_o,
   output logic [num_source_p*header_width_p-1:0] src_rev_header_o,
   output logic [num_source_p*data_width_p-1:0]   src_rev_data_o,
   output logic [num_source_p-1:0]                src_rev_v_o,
   input  logic [num_source_p-1:0]                src_rev_ready_and_i,
   output logic                                   unexpected_rev_o
);

   localparam int lg_tag = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
   localparam int cnt_w  = $clog2(tag_els_p + 1);
   localparam logic [cnt_w-1:0]  tag_full_cnt = cnt_w'(tag_els_p);
   localparam logic [lg_tag-1:0] tag_last     = lg_tag'(tag_els_p - 1);
   localparam logic [lg_src-1:0] src_last     = lg_src'(num_source_p - 1);
   localparam logic [lg_snk-1:0] snk_last     = lg_snk'(num_sink_p - 1);

   logic [1:0]                buf_cnt  [num_sink_p];
   logic                      buf_wptr [num_sink_p];
   logic                      buf_rptr [num_sink_p];
   logic [header_width_p-1:0] buf_hdr  [num_sink_p][2];
   logic [data_width_p-1:0]   buf_data [num_sink_p][2];

   logic [lg_src-1:0]         tag_mem  [num_sink_p][tag_els_p];
   logic [lg_tag-1:0]         tag_wptr [num_sink_p];
   logic [lg_tag-1:0]         tag_rptr [num_sink_p];
   logic [cnt_w-1:0]          tag_cnt  [num_sink_p];

   logic [lg_src-1:0]         fwd_ptr  [num_sink_p];
   logic [lg_src-1:0]         fwd_win  [num_sink_p];
   logic [lg_snk-1:0]         rev_ptr  [num_source_p];
   logic [lg_snk-1:0]         rev_win  [num_source_p];

   logic [num_sink_p-1:0]     fwd_push;
   logic [num_sink_p-1:0]     fwd_pop;
   logic [num_sink_p-1:0]     tag_pop;
   logic [num_source_p-1:0]   rev_adv;
   logic                      unexpected_set;

   // Grant looks only at local occupancy, never at sink ready, so the source-side
   // ready is a clean function of registered state plus the request lines.
   // NOTE: combinational blocks use blocking '=' and give every output a default
   // first; sequential blocks use '<=' only.
   always_comb begin
      logic found;
      int   idx;
      src_fwd_ready_and_o = '0;
      fwd_push            = '0;
      for (int j = 0; j < num_sink_p; j++) begin
         found      = 1'b0;
         fwd_win[j] = '0;
         for (int k = 0; k < num_source_p; k++) begin
            idx = (int'(fwd_ptr[j]) + k) % num_source_p;
            if (!found && src_fwd_v_i[idx] &&
                int'(src_fwd_dst_i[idx*lg_snk +: lg_snk]) == j) begin
               found      = 1'b1;
               fwd_win[j] = lg_src'(idx);
            end
         end
         if (found && reset_n_i && buf_cnt[j] != 2'd2 && tag_cnt[j] != tag_full_cnt) begin
            fwd_push[j]                     = 1'b1;
            src_fwd_ready_and_o[fwd_win[j]] = 1'b1;
         end
      end
   end

   always_comb begin
      snk_fwd_v_o      = '0;
      snk_fwd_header_o = '0;
      snk_fwd_data_o   = '0;
      fwd_pop          = '0;
      for (int j = 0; j < num_sink_p; j++) begin
         snk_fwd_v_o[j] = (buf_cnt[j] != 2'd0);
         snk_fwd_header_o[j*header_width_p +: header_width_p] = buf_hdr[j][buf_rptr[j]];
         snk_fwd_data_o[j*data_width_p +: data_width_p]       = buf_data[j][buf_rptr[j]];
         fwd_pop[j] = (buf_cnt[j] != 2'd0) && snk_fwd_ready_and_i[j];
      end
   end

   // Response path: each sink targets the source at its tag head; each source
   // picks one such sink round-robin.
   always_comb begin
      logic found;
      int   idx;
      src_rev_v_o         = '0;
      src_rev_header_o    = '0;
      src_rev_data_o      = '0;
      snk_rev_ready_and_o = '0;
      tag_pop             = '0;
      rev_adv             = '0;
      unexpected_set      = 1'b0;
      for (int s = 0; s < num_source_p; s++) begin
         found      = 1'b0;
         rev_win[s] = '0;
         for (int k = 0; k < num_sink_p; k++) begin
            idx = (int'(rev_ptr[s]) + k) % num_sink_p;
            if (!found && snk_rev_v_i[idx] && tag_cnt[idx] != '0 &&
                int'(tag_mem[idx][tag_rptr[idx]]) == s) begin
               found      = 1'b1;
               rev_win[s] = lg_snk'(idx);
            end
         end
         if (found) begin
            src_rev_v_o[s] = 1'b1;
            src_rev_header_o[s*header_width_p +: header_width_p] =
               snk_rev_header_i[int'(rev_win[s])*header_width_p +: header_width_p];
            src_rev_data_o[s*data_width_p +: data_width_p] =
               snk_rev_data_i[int'(rev_win[s])*data_width_p +: data_width_p];
            if (src_rev_ready_and_i[s]) begin
               snk_rev_ready_and_o[rev_win[s]] = 1'b1;
               tag_pop[rev_win[s]]             = 1'b1;
               rev_adv[s]                      = 1'b1;
            end
         end
      end
      for (int j = 0; j < num_sink_p; j++) begin
         if (reset_n_i && snk_rev_v_i[j] && tag_cnt[j] == '0) begin
            snk_rev_ready_and_o[j] = 1'b1;
            unexpected_set         = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int j = 0; j < num_sink_p; j++) begin
            buf_cnt[j]  <= '0;
            buf_wptr[j] <= 1'b0;
            buf_rptr[j] <= 1'b0;
            tag_cnt[j]  <= '0;
            tag_wptr[j] <= '0;
            tag_rptr[j] <= '0;
            fwd_ptr[j]  <= '0;
         end
         for (int s = 0; s < num_source_p; s++) rev_ptr[s] <= '0;
         unexpected_rev_o <= 1'b0;
      end else begin
         for (int j = 0; j < num_sink_p; j++) begin
            if (fwd_push[j]) begin
               buf_wptr[j] <= ~buf_wptr[j];
               tag_wptr[j] <= (tag_wptr[j] == tag_last) ? '0 : tag_wptr[j] + 1'b1;
               fwd_ptr[j]  <= (fwd_win[j] == src_last) ? '0 : fwd_win[j] + 1'b1;
            end
            if (fwd_pop[j]) buf_rptr[j] <= ~buf_rptr[j];
            if (tag_pop[j]) tag_rptr[j] <= (tag_rptr[j] == tag_last) ? '0 : tag_rptr[j] + 1'b1;
            case ({fwd_push[j], fwd_pop[j]})
               2'b10:   buf_cnt[j] <= buf_cnt[j] + 2'd1;
               2'b01:   buf_cnt[j] <= buf_cnt[j] - 2'd1;
               default: buf_cnt[j] <= buf_cnt[j];
            endcase
            case ({fwd_push[j], tag_pop[j]})
               2'b10:   tag_cnt[j] <= tag_cnt[j] + 1'b1;
               2'b01:   tag_cnt[j] <= tag_cnt[j] - 1'b1;
               default: tag_cnt[j] <= tag_cnt[j];
            endcase
         end
         for (int s = 0; s < num_source_p; s++) begin
            if (rev_adv[s]) rev_ptr[s] <= (rev_win[s] == snk_last) ? '0 : rev_win[s] + 1'b1;
         end
         if (unexpected_set) unexpected_rev_o <= 1'b1;
      end
   end

   // NOTE: payload storage has no reset; reset-cleared counts and pointers ensure
   // no entry is read before it has been written.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < num_sink_p; j++) begin
         if (fwd_push[j]) begin
            buf_hdr[j][buf_wptr[j]]  <= src_fwd_header_i[int'(fwd_win[j])*header_width_p +: header_width_p];
            buf_data[j][buf_wptr[j]] <= src_fwd_data_i[int'(fwd_win[j])*data_width_p +: data_width_p];
            tag_mem[j][tag_wptr[j]]  <= fwd_win[j];
         end
      end
   end

endmodule

// File: tb/tb_bp_me_mem_router.sv
// Directed self-checking bench for bp_me_mem_router with default parameters
// (2 sources, 4 sinks, 64-bit header/data, 4 tags per sink).
module tb_bp_me_mem_router;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic [127:0]  src_fwd_header_i;
   logic [127:0]  src_fwd_data_i;
   logic [1:0]    src_fwd_v_i;
   logic [3:0]    src_fwd_dst_i;
   logic [1:0]    src_fwd_ready_and_o;
   logic [255:0]  snk_fwd_header_o;
   logic [255:0]  snk_fwd_data_o;
   logic [3:0]    snk_fwd_v_o;
   logic [3:0]    snk_fwd_ready_and_i;
   logic [255:0]  snk_rev_header_i;
   logic [255:0]  snk_rev_data_i;
   logic [3:0]    snk_rev_v_i;
   logic [3:0]    snk_rev_ready_and_o;
   logic [127:0]  src_rev_header_o;
   logic [127:0]  src_rev_data_o;
   logic [1:0]    src_rev_v_o;
   logic [1:0]    src_rev_ready_and_i;
   logic          unexpected_rev_o;

   int checks = 0;
   int errors = 0;

   bp_me_mem_router dut (
      .clk_i               (clk_i),
      .reset_n_i           (reset_n_i),
      .src_fwd_header_i    (src_fwd_header_i),
      .src_fwd_data_i      (src_fwd_data_i),
      .src_fwd_v_i         (src_fwd_v_i),
      .src_fwd_dst_i       (src_fwd_dst_i),
      .src_fwd_ready_and_o (src_fwd_ready_and_o),
      .snk_fwd_header_o    (snk_fwd_header_o),
      .snk_fwd_data_o      (snk_fwd_data_o),
      .snk_fwd_v_o         (snk_fwd_v_o),
      .snk_fwd_ready_and_i (snk_fwd_ready_and_i),
      .snk_rev_header_i    (snk_rev_header_i),
      .snk_rev_data_i      (snk_rev_data_i),
      .snk_rev_v_i         (snk_rev_v_i),
      .snk_rev_ready_and_o (snk_rev_ready_and_o),
      .src_rev_header_o    (src_rev_header_o),
      .src_rev_data_o      (src_rev_data_o),
      .src_rev_v_o         (src_rev_v_o),
      .src_rev_ready_and_i (src_rev_ready_and_i),
      .unexpected_rev_o    (unexpected_rev_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_src(input int i, input logic v, input logic [1:0] dst,
                            input logic [63:0] hdr, input logic [63:0] dat);
      src_fwd_v_i[i]              = v;
      src_fwd_dst_i[i*2 +: 2]     = dst;
      src_fwd_header_i[i*64 +: 64] = hdr;
      src_fwd_data_i[i*64 +: 64]   = dat;
   endtask

   task automatic drive_rev(input int j, input logic v, input logic [63:0] hdr,
                            input logic [63:0] dat);
      snk_rev_v_i[j]               = v;
      snk_rev_header_i[j*64 +: 64] = hdr;
      snk_rev_data_i[j*64 +: 64]   = dat;
   endtask

   task automatic test_reset;
      reset_n_i = 1'b0;
      drive_src(0, 1'b1, 2'd0, 64'h1, 64'h1);
      drive_src(1, 1'b1, 2'd0, 64'h2, 64'h2);
      snk_rev_v_i = 4'b1111;
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL reset_src_ready: got %b exp 00", src_fwd_ready_and_o); end
      checks++; if (snk_rev_ready_and_o !== 4'b0000) begin errors++; $display("FAIL reset_snk_rev_ready: got %b exp 0000", snk_rev_ready_and_o); end
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL reset_snk_fwd_v: got %b exp 0000", snk_fwd_v_o); end
      checks++; if (src_rev_v_o !== 2'b00) begin errors++; $display("FAIL reset_src_rev_v: got %b exp 00", src_rev_v_o); end
      checks++; if (unexpected_rev_o !== 1'b0) begin errors++; $display("FAIL reset_unexpected: got %b exp 0", unexpected_rev_o); end
      src_fwd_v_i = '0;
      snk_rev_v_i = '0;
      tick; tick;
      reset_n_i = 1'b1;
      tick;
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL reset_release_fwd_v: got %b exp 0000", snk_fwd_v_o); end
   endtask

   task automatic test_basic;
      drive_src(0, 1'b1, 2'd2, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL basic_accept: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      #1;
      checks++; if (snk_fwd_v_o !== 4'b0100) begin errors++; $display("FAIL basic_fwd_v: got %b exp 0100", snk_fwd_v_o); end
      checks++; if (snk_fwd_header_o[2*64 +: 64] !== 64'h1234_5678_9abc_def0) begin errors++; $display("FAIL basic_fwd_hdr: got %h exp 123456789abcdef0", snk_fwd_header_o[2*64 +: 64]); end
      checks++; if (snk_fwd_data_o[2*64 +: 64] !== 64'h0fed_cba9_8765_4321) begin errors++; $display("FAIL basic_fwd_data: got %h exp 0fedcba987654321", snk_fwd_data_o[2*64 +: 64]); end
      tick;
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL basic_fwd_drained: got %b exp 0000", snk_fwd_v_o); end
      drive_rev(2, 1'b1, 64'h5555_0000_aaaa_0001, 64'h7777_0000_3333_0002);
      #1;
      checks++; if (src_rev_v_o !== 2'b01) begin errors++; $display("FAIL basic_rev_v: got %b exp 01", src_rev_v_o); end
      checks++; if (src_rev_header_o[63:0] !== 64'h5555_0000_aaaa_0001) begin errors++; $display("FAIL basic_rev_hdr: got %h exp 55550000aaaa0001", src_rev_header_o[63:0]); end
      checks++; if (src_rev_data_o[63:0] !== 64'h7777_0000_3333_0002) begin errors++; $display("FAIL basic_rev_data: got %h exp 7777000033330002", src_rev_data_o[63:0]); end
      checks++; if (snk_rev_ready_and_o !== 4'b0100) begin errors++; $display("FAIL basic_rev_ready: got %b exp 0100", snk_rev_ready_and_o); end
      tick;
      drive_rev(2, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (src_rev_v_o !== 2'b00) begin errors++; $display("FAIL basic_rev_done: got %b exp 00", src_rev_v_o); end
   endtask

   task automatic test_round_robin;
      drive_src(0, 1'b1, 2'd1, 64'hA0, 64'hD0);
      drive_src(1, 1'b1, 2'd1, 64'hA1, 64'hD1);
      for (int k = 0; k < 4; k++) begin
         logic [1:0]  exp_rdy;
         logic [63:0] exp_hdr;
         exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_hdr = (k % 2 == 0) ? 64'hA0 : 64'hA1;
         #1;
         checks++; if (src_fwd_ready_and_o !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, src_fwd_ready_and_o, exp_rdy); end
         tick;
         checks++; if (snk_fwd_v_o[1] !== 1'b1 || snk_fwd_header_o[64 +: 64] !== exp_hdr) begin errors++; $display("FAIL rr_fwd[%0d]: got v=%b hdr=%h exp v=1 hdr=%h", k, snk_fwd_v_o[1], snk_fwd_header_o[64 +: 64], exp_hdr); end
      end
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL rr_tag_full: got %b exp 00", src_fwd_ready_and_o); end
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      drive_src(1, 1'b0, 2'd0, 64'h0, 64'h0);
      tick;
      for (int k = 0; k < 4; k++) begin
         logic [1:0]  exp_v;
         logic [63:0] got_hdr;
         exp_v = (k % 2 == 0) ? 2'b01 : 2'b10;
         drive_rev(1, 1'b1, 64'hB0 + 64'(k), 64'hE0 + 64'(k));
         #1;
         got_hdr = (k % 2 == 0) ? src_rev_header_o[63:0] : src_rev_header_o[127:64];
         checks++; if (src_rev_v_o !== exp_v || got_hdr !== 64'hB0 + 64'(k)) begin errors++; $display("FAIL rr_rev[%0d]: got v=%b hdr=%h exp v=%b hdr=%h", k, src_rev_v_o, got_hdr, exp_v, 64'hB0 + 64'(k)); end
         tick;
      end
      drive_rev(1, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (src_rev_v_o !== 2'b00) begin errors++; $display("FAIL rr_rev_done: got %b exp 00", src_rev_v_o); end
   endtask

   task automatic test_tag_full;
      snk_fwd_ready_and_i[3] = 1'b0;
      drive_src(0, 1'b1, 2'd3, 64'hC0, 64'hF0);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL tag_acc0: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b1, 2'd3, 64'hC1, 64'hF1);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL tag_acc1: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b1, 2'd3, 64'hC2, 64'hF2);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL tag_buf_full: got %b exp 00", src_fwd_ready_and_o); end
      checks++; if (snk_fwd_v_o[3] !== 1'b1 || snk_fwd_header_o[3*64 +: 64] !== 64'hC0) begin errors++; $display("FAIL tag_buf_head: got v=%b hdr=%h exp v=1 hdr=c0", snk_fwd_v_o[3], snk_fwd_header_o[3*64 +: 64]); end
      tick;
      snk_fwd_ready_and_i[3] = 1'b1;
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL tag_ready_indep: got %b exp 00", src_fwd_ready_and_o); end
      tick;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL tag_acc2: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b1, 2'd3, 64'hC3, 64'hF3);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL tag_acc3: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b1, 2'd3, 64'hC4, 64'hF4);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL tag_fifo_full: got %b exp 00", src_fwd_ready_and_o); end
      tick;
      drive_rev(3, 1'b1, 64'hD0, 64'h0);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b00) begin errors++; $display("FAIL tag_full_pop_same_cycle: got %b exp 00", src_fwd_ready_and_o); end
      checks++; if (src_rev_v_o !== 2'b01 || snk_rev_ready_and_o !== 4'b1000) begin errors++; $display("FAIL tag_pop_rev: got v=%b rdy=%b exp v=01 rdy=1000", src_rev_v_o, snk_rev_ready_and_o); end
      tick;
      drive_rev(3, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL tag_acc4: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      #1;
      checks++; if (snk_fwd_v_o !== 4'b1000 || snk_fwd_header_o[3*64 +: 64] !== 64'hC4) begin errors++; $display("FAIL tag_fwd4: got v=%b hdr=%h exp v=1000 hdr=c4", snk_fwd_v_o, snk_fwd_header_o[3*64 +: 64]); end
      tick;
      for (int k = 0; k < 4; k++) begin
         drive_rev(3, 1'b1, 64'hD1 + 64'(k), 64'h0);
         #1;
         checks++; if (src_rev_v_o !== 2'b01 || src_rev_header_o[63:0] !== 64'hD1 + 64'(k)) begin errors++; $display("FAIL tag_drain[%0d]: got v=%b hdr=%h exp v=01 hdr=%h", k, src_rev_v_o, src_rev_header_o[63:0], 64'hD1 + 64'(k)); end
         tick;
      end
      drive_rev(3, 1'b0, 64'h0, 64'h0);
   endtask

   task automatic test_rev_arbitration;
      drive_src(0, 1'b1, 2'd0, 64'h10, 64'h0);
      tick;
      drive_src(0, 1'b1, 2'd1, 64'h11, 64'h0);
      tick;
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      tick;
      src_rev_ready_and_i[0] = 1'b0;
      drive_rev(0, 1'b1, 64'h20, 64'h30);
      drive_rev(1, 1'b1, 64'h21, 64'h31);
      #1;
      checks++; if (src_rev_v_o[0] !== 1'b1 || src_rev_header_o[63:0] !== 64'h20) begin errors++; $display("FAIL arb_stall_v: got v=%b hdr=%h exp v=1 hdr=20", src_rev_v_o[0], src_rev_header_o[63:0]); end
      checks++; if (snk_rev_ready_and_o !== 4'b0000) begin errors++; $display("FAIL arb_stall_ready: got %b exp 0000", snk_rev_ready_and_o); end
      tick;
      src_rev_ready_and_i[0] = 1'b1;
      #1;
      checks++; if (snk_rev_ready_and_o !== 4'b0001 || src_rev_data_o[63:0] !== 64'h30) begin errors++; $display("FAIL arb_first: got rdy=%b data=%h exp rdy=0001 data=30", snk_rev_ready_and_o, src_rev_data_o[63:0]); end
      tick;
      drive_rev(0, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (snk_rev_ready_and_o !== 4'b0010 || src_rev_header_o[63:0] !== 64'h21) begin errors++; $display("FAIL arb_second: got rdy=%b hdr=%h exp rdy=0010 hdr=21", snk_rev_ready_and_o, src_rev_header_o[63:0]); end
      tick;
      drive_rev(1, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (src_rev_v_o !== 2'b00) begin errors++; $display("FAIL arb_done: got %b exp 00", src_rev_v_o); end
   endtask

   task automatic test_unexpected;
      drive_rev(2, 1'b1, 64'hEE, 64'hEF);
      #1;
      checks++; if (snk_rev_ready_and_o !== 4'b0100) begin errors++; $display("FAIL unexp_consumed: got %b exp 0100", snk_rev_ready_and_o); end
      checks++; if (src_rev_v_o !== 2'b00) begin errors++; $display("FAIL unexp_no_route: got %b exp 00", src_rev_v_o); end
      tick;
      drive_rev(2, 1'b0, 64'h0, 64'h0);
      #1;
      checks++; if (unexpected_rev_o !== 1'b1) begin errors++; $display("FAIL unexp_set: got %b exp 1", unexpected_rev_o); end
      tick; tick; tick;
      checks++; if (unexpected_rev_o !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b exp 1", unexpected_rev_o); end
   endtask

   task automatic test_reset_mid;
      snk_fwd_ready_and_i[0] = 1'b0;
      drive_src(0, 1'b1, 2'd0, 64'h50, 64'h0);
      tick;
      drive_src(0, 1'b1, 2'd0, 64'h51, 64'h0);
      tick;
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      #1;
      checks++; if (snk_fwd_v_o !== 4'b0001 || snk_fwd_header_o[63:0] !== 64'h50) begin errors++; $display("FAIL rst_mid_buffered: got v=%b hdr=%h exp v=0001 hdr=50", snk_fwd_v_o, snk_fwd_header_o[63:0]); end
      #2;
      reset_n_i = 1'b0;
      #1;
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_async_v: got %b exp 0000", snk_fwd_v_o); end
      checks++; if (unexpected_rev_o !== 1'b0) begin errors++; $display("FAIL rst_mid_unexpected: got %b exp 0", unexpected_rev_o); end
      tick; tick;
      reset_n_i = 1'b1;
      snk_fwd_ready_and_i[0] = 1'b1;
      tick;
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_stale1: got %b exp 0000", snk_fwd_v_o); end
      tick;
      checks++; if (snk_fwd_v_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_stale2: got %b exp 0000", snk_fwd_v_o); end
      drive_src(0, 1'b1, 2'd0, 64'h52, 64'h62);
      #1;
      checks++; if (src_fwd_ready_and_o !== 2'b01) begin errors++; $display("FAIL rst_mid_resume_acc: got %b exp 01", src_fwd_ready_and_o); end
      tick;
      drive_src(0, 1'b0, 2'd0, 64'h0, 64'h0);
      #1;
      checks++; if (snk_fwd_v_o !== 4'b0001 || snk_fwd_header_o[63:0] !== 64'h52) begin errors++; $display("FAIL rst_mid_resume_fwd: got v=%b hdr=%h exp v=0001 hdr=52", snk_fwd_v_o, snk_fwd_header_o[63:0]); end
      tick;
   endtask

   initial begin
      reset_n_i           = 1'b0;
      src_fwd_header_i    = '0;
      src_fwd_data_i      = '0;
      src_fwd_v_i         = '0;
      src_fwd_dst_i       = '0;
      snk_fwd_ready_and_i = 4'b1111;
      snk_rev_header_i    = '0;
      snk_rev_data_i      = '0;
      snk_rev_v_i         = '0;
      src_rev_ready_and_i = 2'b11;
      tick;
      test_reset;
      test_basic;
      test_round_robin;
      test_tag_full;
      test_rev_arbitration;
      test_unexpected;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
